// File: rtl/bit_unpacker_pkg.sv
// Shared constants, count type and request-length decode for the bit unpacker.
package bit_unpacker_pkg;
  localparam int WORD_W = 32;
  localparam int BUF_W  = 64;
  localparam int CNT_W  = 7;
  localparam int REQ_W  = 4;
  localparam int NLEN_W = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  // A zero request length encodes the full 16-bit request.
  function automatic logic [NLEN_W-1:0] decode_reqlen(input logic [REQ_W-1:0] r);
    return (r == '0) ? NLEN_W'(16) : {1'b0, r};
  endfunction
endpackage

// File: rtl/bit_unpacker_align.sv
// Combinational extract/shift/insert on the bit buffer.
// Bit order: MSB-first by default, LSB-first when BIT_UNPACKER_LSB_FIRST_EN is defined.
module bit_unpacker_align
  import bit_unpacker_pkg::*;
(
  input  logic [BUF_W-1:0]  i_buf,
  input  logic [NLEN_W-1:0] i_n,
  input  logic              i_take,
  input  logic [CNT_W-1:0]  i_ofs,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_load,
  output logic [15:0]       o_data,
  output logic [BUF_W-1:0]  o_buf
);
  logic [CNT_W-1:0] w_sh;
  logic [BUF_W-1:0] w_kept;
  logic [BUF_W-1:0] w_ins;

  assign w_sh = i_take ? CNT_W'(i_n) : '0;

`ifdef BIT_UNPACKER_LSB_FIRST_EN
  logic [BUF_W-1:0] w_mask;
  assign w_mask = (BUF_W'(1) << i_n) - BUF_W'(1);
  assign o_data = 16'(i_buf & w_mask);
  assign w_kept = i_buf >> w_sh;
  assign w_ins  = {{(BUF_W-WORD_W){1'b0}}, i_word} << i_ofs;
`else
  // Oldest bit sits at the top; bits below the live count are always zero.
  assign o_data = 16'(i_buf >> (CNT_W'(BUF_W) - CNT_W'(i_n)));
  assign w_kept = i_buf << w_sh;
  assign w_ins  = {i_word, {(BUF_W-WORD_W){1'b0}}} >> i_ofs;
`endif

  assign o_buf = w_kept | (i_load ? w_ins : '0);
endmodule

// File: rtl/bit_unpacker.sv
// Pops 32-bit FIFO words into a 64-bit buffer and serves 1-16 bit requests.
// Define BIT_UNPACKER_LSB_FIRST_EN for LSB-first bit order.
module bit_unpacker #(
  parameter int WORD_W = 32,
  parameter int BUF_W  = 64,
  parameter int LEN_W  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_data,
  output logic              fifo_pop,
  input  logic              reqin,
  input  logic [3:0]        reqlen,
  output logic              reqready,
  output logic              pushout,
  output logic [15:0]       dataout,
  output logic [LEN_W-1:0]  lenout
);
  import bit_unpacker_pkg::*;

  logic [BUF_W-1:0]  r_buf;
  logic [BUF_W-1:0]  w_buf_nxt;
  cnt_t              r_count;
  cnt_t              w_cnt_after;
  logic              r_inflight;
  logic [LEN_W-1:0]  r_lenout;
  logic              r_pushout;
  logic [15:0]       r_dataout;
  logic [15:0]       w_data;
  logic [NLEN_W-1:0] w_n;
  logic              w_grant;

  assign w_n      = decode_reqlen(reqlen);
  assign reqready = (r_count >= CNT_W'(w_n));
  assign w_grant  = reqin && reqready;

  // Only pop when the word is guaranteed to fit after this cycle's consume.
  assign fifo_pop = !reset && !fifo_empty && !r_inflight &&
                    (r_count <= CNT_W'(WORD_W));

  assign w_cnt_after = r_count - (w_grant ? CNT_W'(w_n) : CNT_W'(0));

  bit_unpacker_align u_align (
    .i_buf  (r_buf),
    .i_n    (w_n),
    .i_take (w_grant),
    .i_ofs  (w_cnt_after),
    .i_word (fifo_data),
    .i_load (r_inflight),
    .o_data (w_data),
    .o_buf  (w_buf_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buf      <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_lenout   <= '0;
      r_pushout  <= 1'b0;
      r_dataout  <= '0;
    end else begin
      r_inflight <= fifo_pop;
      if (w_grant || r_inflight) r_buf <= w_buf_nxt;
      r_count    <= w_cnt_after + (r_inflight ? CNT_W'(WORD_W) : CNT_W'(0));
      r_pushout  <= w_grant;
      r_dataout  <= w_grant ? w_data : '0;
      if (w_grant) r_lenout <= r_lenout + LEN_W'(w_n);
    end
  end

  assign pushout = r_pushout;
  assign dataout = r_dataout;
  assign lenout  = r_lenout;
endmodule

// File: tb/tb_bit_unpacker.sv
// Self-checking bench for bit_unpacker: FIFO model plus bit-stream reference.
module tb_bit_unpacker;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty;
  logic [31:0] fifo_data = '0;
  logic        fifo_pop;
  logic        reqin = 1'b0;
  logic [3:0]  reqlen = '0;
  logic        reqready;
  logic        pushout;
  logic [15:0] dataout;
  logic [14:0] lenout;

  always #5 clock = ~clock;

  bit_unpacker dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .reqin      (reqin),
    .reqlen     (reqlen),
    .reqready   (reqready),
    .pushout    (pushout),
    .dataout    (dataout),
    .lenout     (lenout)
  );

  // Word FIFO with a registered read port (1-cycle latency).
  logic [31:0] mem [2048];
  int head = 0;
  int tail = 0;
  assign fifo_empty = (head == tail);
  always @(posedge clock) begin
    if (reset) head <= tail;
    else if (fifo_pop) begin
      fifo_data <= mem[head % 2048];
      head      <= head + 1;
    end
  end

  // Reference: the words form one bit stream; each grant takes the next n bits.
  bit          sq[$];
  int          total = 0;
  int          grants = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] last_exp;

  int   mon_err = 0;
  int   n_push = 0;
  logic pop_prev = 1'b0;
  always @(negedge clock) begin
    #2;
    if (reset) pop_prev <= 1'b0;
    else begin
      if (fifo_pop && fifo_empty) mon_err <= mon_err + 1;
      if (fifo_pop && pop_prev)   mon_err <= mon_err + 1;
      pop_prev <= fifo_pop;
      if (pushout) n_push <= n_push + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[tail % 2048] = w;
    tail++;
    for (int i = 0; i < 32; i++) begin
`ifdef BIT_UNPACKER_LSB_FIRST_EN
      sq.push_back(w[i]);
`else
      sq.push_back(w[31-i]);
`endif
    end
  endtask

  function automatic logic [15:0] take_bits(input int n);
    logic [15:0] v;
    bit b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      b = 1'b0;
      if (sq.size() > 0) b = sq.pop_front();
`ifdef BIT_UNPACKER_LSB_FIRST_EN
      v[i] = b;
`else
      v = {v[14:0], b};
`endif
    end
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the grant with reqin low.
  task automatic req(input int n);
    bit ok;
    ok = 1'b0;
    reqlen = 4'(n);
    reqin  = 1'b1;
    #1;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (reqready === 1'b1) begin
        @(posedge clock);
        ok = 1'b1;
      end else begin
        @(negedge clock);
        #1;
      end
    end
    if (!ok) begin
      chk("req_timeout", 32'(ok), 32'(1));
      reqin = 1'b0;
      @(negedge clock);
      return;
    end
    @(negedge clock);
    #1;
    last_exp = take_bits(n);
    total += n;
    grants++;
    chk("pushout", 32'(pushout), 32'(1));
    chk("dataout", 32'(dataout), 32'(last_exp));
    chk("lenout", 32'(lenout), 32'(total % 32768));
    reqin = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_pop"}, 32'(fifo_pop), 0);
    chk({tag, "_ready"}, 32'(reqready), 0);
    chk({tag, "_push"}, 32'(pushout), 0);
    chk({tag, "_data"}, 32'(dataout), 0);
    chk({tag, "_len"}, 32'(lenout), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    reqin = 1'b0;
    #1;
    check_idle_outputs("rst");
    sq.delete();
    total = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    repeat (2) @(negedge clock);
    #1;
    check_idle_outputs("por");
    reset = 1'b0;
    @(negedge clock);

    // Two 4-bit reads from a known word.
    push_word(32'hA5C3_0F01);
    req(4);
`ifdef BIT_UNPACKER_LSB_FIRST_EN
    chk("t1_first", 32'(last_exp), 32'h1);
`else
    chk("t1_first", 32'(last_exp), 32'hA);
`endif
    chk("t1_len4", 32'(total), 4);
    req(4);
`ifdef BIT_UNPACKER_LSB_FIRST_EN
    chk("t1_second", 32'(last_exp), 32'h0);
`else
    chk("t1_second", 32'(last_exp), 32'h5);
`endif

    // 16-bit request against an empty FIFO stalls until a word arrives.
    do_reset();
    reqlen = 4'd0;
    reqin  = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    chk("t2_notready", 32'(reqready), 0);
    chk("t2_nopush", 32'(pushout), 0);
    push_word(32'h1234_5678);
    req(16);
`ifdef BIT_UNPACKER_LSB_FIRST_EN
    chk("t2_data", 32'(last_exp), 32'h5678);
`else
    chk("t2_data", 32'(last_exp), 32'h1234);
`endif
    chk("t2_len", 32'(total), 16);

    // Back-to-back 16-bit reads over four queued words.
    do_reset();
    for (int i = 0; i < 4; i++) push_word($urandom);
    for (int i = 0; i < 8; i++) req(16);

    // Word arrives in the same cycle as a 12-bit grant with 20 bits held.
    do_reset();
    push_word($urandom);
    req(12);
    push_word($urandom);
    @(negedge clock);
    req(12);
    req(16);
    req(12);
    reqlen = 4'd0;
    #1;
    chk("t4_16_notready", 32'(reqready), 0);
    reqlen = 4'd12;
    #1;
    chk("t4_12_ready", 32'(reqready), 1);
    @(negedge clock);

    // lenout wraps: 6554*5 + 3 = 2^15 + 5 bits delivered.
    do_reset();
    for (int i = 0; i < 1025; i++) push_word($urandom);
    for (int i = 0; i < 6554; i++) req(5);
    req(3);
    chk("t5_wrap", 32'(lenout), 5);

    // Reset while a popped word is in flight: stale read data must be ignored.
    w = $urandom;
    push_word(w);
    #1;
    chk("t6_pop", 32'(fifo_pop), 1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_idle_outputs("t6_rst");
    sq.delete();
    total = 0;
    @(negedge clock);
    reset  = 1'b0;
    reqlen = 4'd1;
    reqin  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      chk("t6_count0", 32'(reqready), 0);
      chk("t6_nopush", 32'(pushout), 0);
    end
    reqin = 1'b0;
    repeat (3) @(negedge clock);

    chk("pop_rules", 32'(mon_err), 0);
    chk("pushout_count", 32'(n_push), 32'(grants));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_unpacker.md
# bit_unpacker

Downstream stage of the 32-bit word FIFO in the bitstream path. Pops 32-bit words from the FIFO's registered read port, holds them in a 64-bit bit buffer, and serves variable-length bit requests of 1–16 bits per cycle. Each grant returns the requested bits right-aligned, with a running count of bits delivered. The block sits between the word FIFO and the bit-level consumer that issues `reqin`/`reqlen`.

## Interface
Parameters:
- `WORD_W`, 32: FIFO word width.
- `BUF_W`, 64: bit buffer depth; must equal 2·`WORD_W`.
- `LEN_W`, 15: width of `lenout`.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO has no word.
- `fifo_data`  in  32  FIFO read data; valid the cycle after `fifo_pop`.
- `fifo_pop`  out  1  pop one word this cycle.
- `reqin`  in  1  bit request valid; held until granted.
- `reqlen`  in  4  bits requested; 1–15 literal, 0 = 16.
- `reqready`  out  1  buffer holds at least `reqlen` bits.
- `pushout`  out  1  one-cycle strobe: `dataout`/`lenout` valid.
- `dataout`  out  16  requested bits, right-aligned, upper bits zero.
- `lenout`  out  15  total bits delivered modulo 2^15, including this grant.

## Operation
- State: `buf[63:0]`, `count` (0–64, 7 bits), `inflight` flag, `lenout` accumulator.
- Fill control: `fifo_pop` = !`fifo_empty` && !`inflight` && `count` ≤ 32 (combinational). A pop sets `inflight` for exactly one cycle. The next cycle, `fifo_data` is written at bit offset `count_after_consume`; then `count += 32` and `inflight` clears.
- `fifo_pop` is never asserted while `fifo_empty` is high.
- Grant: `reqready` = (`count` ≥ n), where n = `reqlen` decoded (0 → 16). Only bits already in `buf` count; an in-flight word does not. A grant occurs when `reqin` && `reqready`.
- Default bit order, MSB-first: buffer is left-aligned, the oldest bit is `buf[63]`, and a grant takes the top n bits and shifts `buf` left by n.
- Same-cycle grant and word arrival: consume first, then load the word at the new `count`. Result: `count` = `count` − n + 32. Never overflows, because `count` ≤ 32 at pop.
- `lenout` adds n on each grant and wraps silently at 2^15.
- Request with insufficient bits: no grant and no side effects; `reqin`/`reqlen` must stay stable until granted.
- Reset (asynchronous, any time): `count`=0, `inflight`=0, `buf`=0, `lenout`=0. Outputs reset to `fifo_pop`=0, `reqready`=0, `pushout`=0, `dataout`=0, `lenout`=0. A FIFO word whose pop preceded reset is discarded.

## Timing
- FIFO read latency is 1 cycle: pop at edge t, data captured at edge t+1.
- Request-to-response: grant at edge t; `pushout`, `dataout`, `lenout` are registered and valid after edge t+1, for one cycle.
- Throughput: one grant per cycle, up to 16 bits per cycle. Sustained 16 bits per cycle needs one FIFO word every 2 cycles.
- From empty: first word pop at cycle 0, buffer filled at cycle 1. The earliest grant is cycle 1 (`reqready` high), with `pushout` at cycle 2.

## Configuration
- `BIT_UNPACKER_LSB_FIRST_EN` defined: LSB-first order. The buffer is right-aligned, the oldest bit is `buf[0]`, and a grant takes `buf[n-1:0]` and shifts right by n. New words load at bit offset `count`.
- Undefined: MSB-first order as described above.
- Handshake and timing are identical in both modes.

## Structure
- Package `bit_unpacker_pkg`:
  - constants `WORD_W`, `BUF_W`, `CNT_W`=7, `REQ_W`=4;
  - function `decode_reqlen` (0→16);
  - typedef for the count.
- Sub-module `bit_unpacker_align`: combinational extract, shift and word-insert of `buf` for a given n and load offset, with order selected by the macro.
- The top level holds the fill control, `count`, `lenout` and the output registers.

## Test plan
- Reset, push word 0xA5C3_0F01, request 4 then 4 → two pulses with `dataout` 0x000A then 0x0005, `lenout` 4 then 8. With the LSB macro: 0x0001, 0x0000.
- Request 16 (`reqlen`=0) with empty FIFO → `reqready`=0 and no `pushout`. Then push 0x1234_5678 → grant, `dataout`=0x1234, `lenout`=16.
- Back-to-back 16-bit requests over 4 queued words → 8 pulses. No pop occurs while `count` > 32 or while `inflight` is set. No pop occurs while `fifo_empty` is high.
- Same-cycle grant and word arrival with `count`=20, n=12 → `count`=40, and the bit sequence is contiguous across the word boundary.
- Deliver 2^15 + 5 bits in 5-bit requests → `lenout` wraps to 5 at the final grant.
- Assert reset while `inflight`=1 → all outputs 0 immediately. The stale `fifo_data` the next cycle is ignored: `count` stays 0.
